pos_integ_scheduler: RTL
========================

Name: pos_integ_scheduler

Overview:
Periodic integration scheduler for the robot position calculator. Every PERIOD_CYCLES it snapshots the global velocities (vx, vy, wz). It then sequences three velocity×dt products through one shared fixed-point multiplier using a req/ack handshake, and commits the increments to the pose accumulators (x, y, theta) in one cycle. It sits between the kinematics velocity source and the pose outputs, and replaces free-running per-axis multipliers.

Parameters:
DATAWIDTH_N, 32, width of all data buses (signed two's complement)
FRACTIONAL_Q, 15, fractional bits of the fixed-point format
PERIOD_CYCLES, 500000, clock cycles between integration ticks (10 ms at 50 MHz)
DT_FIXED, 328, integration step dt in Q(FRACTIONAL_Q) (0.01 s)
PI_FIXED, 102944, pi in Q(FRACTIONAL_Q)

Ports:
POS_SCHED_CLOCK_50  in  1  system clock
POS_SCHED_Reset_InLow  in  1  asynchronous active-low reset
POS_SCHED_SETBEGIN_InLow  in  1  synchronous active-low pose clear / restart
POS_SCHED_VX_InBus  in  N  global vx [m/s], Q15
POS_SCHED_VY_InBus  in  N  global vy [m/s], Q15
POS_SCHED_WZ_InBus  in  N  global wz [rad/s], Q15
POS_SCHED_MULREQ_Out  out  1  multiplier request
POS_SCHED_MULA_OutBus  out  N  multiplier operand A (velocity)
POS_SCHED_MULB_OutBus  out  N  multiplier operand B (DT_FIXED)
POS_SCHED_MULACK_In  in  1  multiplier done; product valid this cycle
POS_SCHED_MULP_InBus  in  N  product, already rescaled: (A*B)>>>Q, truncated
POS_SCHED_POSX_OutBus  out  N  x [m], Q15
POS_SCHED_POSY_OutBus  out  N  y [m], Q15
POS_SCHED_THETA_OutBus  out  N  theta [rad], Q15, range [-PI_FIXED, PI_FIXED)
POS_SCHED_UPDATE_Out  out  1  one-cycle pulse; pose outputs just changed
POS_SCHED_OVERRUN_Out  out  1  sticky: a tick arrived while a sequence was active
POS_SCHED_BUSY_Out  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, low) sets all outputs and registers to 0: pose, MULREQ, MULA/MULB, UPDATE, OVERRUN, BUSY, tick counter. State goes to IDLE.
- Tick counter counts 0..PERIOD_CYCLES-1 and wraps. The tick is asserted in the cycle the count equals PERIOD_CYCLES-1, so the first tick comes PERIOD_CYCLES cycles after reset is released.
- States: IDLE, MUL_X, MUL_Y, MUL_W, COMMIT.
- IDLE + tick: latch VX/VY/WZ into a snapshot, then go to MUL_X. Inputs are not sampled again until the next accepted tick.
- MUL_X/MUL_Y/MUL_W:
  - MULREQ=1, MULA=snapshot vx/vy/wz, MULB=DT_FIXED.
  - Operands and MULREQ are held stable until MULACK=1.
  - On ACK: capture MULP into dx/dy/dw and advance (X→Y→W→COMMIT).
  - MULREQ drops in the cycle after the W ack.
- MULACK while MULREQ=0 is ignored.
- Zero-wait multiplier (ACK in same cycle as REQ): tick at cycle T → REQ high T+1..T+3, COMMIT at T+4, new pose and UPDATE=1 at T+5.
- COMMIT (one cycle), then IDLE:
  - POSX += dx and POSY += dy, each a signed saturating add (clamp to 0x7FFFFFFF / 0x80000000).
  - THETA' = THETA + dw; if THETA' >= PI_FIXED subtract 2*PI_FIXED; if THETA' < -PI_FIXED add 2*PI_FIXED. Compute in N+1 bits; |dw| < PI_FIXED is guaranteed by the velocity range.
  - UPDATE is registered high for exactly the cycle in which the new values first appear.
- Tick while BUSY: the tick is dropped, OVERRUN is set and stays set, the current sequence continues undisturbed.
- SETBEGIN_InLow=0 has highest priority, each cycle it is low:
  - pose = 0, tick counter = 0, OVERRUN = 0, snapshot and increments = 0, MULREQ = 0, state = IDLE, no UPDATE.
  - An in-flight multiply is abandoned; the multiplier must tolerate REQ dropping before ACK.
  - Counting restarts on the first cycle SETBEGIN is high.
- SETBEGIN low during COMMIT: the clear wins and no partial commit occurs.
- Reset mid-sequence: immediate return to reset values.

Test Plan:
- PERIOD_CYCLES=8, zero-wait multiplier model, VX=32768 (1.0), VY=-16384 (-0.5), WZ=0, one tick → POSX=328, POSY=-164, THETA=0; UPDATE high exactly 1 cycle at T+5; MULREQ high for 3 cycles.
- Same stimulus, 10 ticks → POSX=3280, POSY=-1640; UPDATE count = 10; OVERRUN=0.
- THETA preset via 313 ticks of WZ=32768 (dw=328 each; accumulates to 102664), then 1 more tick → 102992 >= 102944, so it wraps to 102992-205888 = -102896.
- POSX driven to 0x7FFFFF00 (pre-load through repeated large VX), next dx=328 → POSX=0x7FFFFFFF, no wrap to negative.
- Multiplier model delays ACK 20 cycles with PERIOD_CYCLES=8 → OVERRUN=1 and stays 1; operands stable while REQ high; pose still updated once per completed sequence.
- SETBEGIN pulsed low for 1 cycle while in MUL_Y with ACK pending → MULREQ=0 next cycle, pose=0, OVERRUN=0, no UPDATE; next tick exactly 8 cycles after SETBEGIN returns high.

Source files
------------

// File: rtl/pos_integ_scheduler.sv
// Periodic pose integrator: snapshots global velocities every PERIOD_CYCLES, forms
// v*dt through one shared handshaked multiplier, then commits x/y/theta in one cycle.
module pos_integ_scheduler #(
    parameter int DATAWIDTH_N   = 32,
    parameter int FRACTIONAL_Q  = 15,
    parameter int PERIOD_CYCLES = 500000,
    parameter int DT_FIXED      = 328,
    parameter int PI_FIXED      = 102944
) (
    input  logic                   POS_SCHED_CLOCK_50,
    input  logic                   POS_SCHED_Reset_InLow,
    input  logic                   POS_SCHED_SETBEGIN_InLow,
    input  logic [DATAWIDTH_N-1:0] POS_SCHED_VX_InBus,
    input  logic [DATAWIDTH_N-1:0] POS_SCHED_VY_InBus,
    input  logic [DATAWIDTH_N-1:0] POS_SCHED_WZ_InBus,
    output logic                   POS_SCHED_MULREQ_Out,
    output logic [DATAWIDTH_N-1:0] POS_SCHED_MULA_OutBus,
    output logic [DATAWIDTH_N-1:0] POS_SCHED_MULB_OutBus,
    input  logic                   POS_SCHED_MULACK_In,
    input  logic [DATAWIDTH_N-1:0] POS_SCHED_MULP_InBus,
    output logic [DATAWIDTH_N-1:0] POS_SCHED_POSX_OutBus,
    output logic [DATAWIDTH_N-1:0] POS_SCHED_POSY_OutBus,
    output logic [DATAWIDTH_N-1:0] POS_SCHED_THETA_OutBus,
    output logic                   POS_SCHED_UPDATE_Out,
    output logic                   POS_SCHED_OVERRUN_Out,
    output logic                   POS_SCHED_BUSY_Out
);

    localparam int N     = DATAWIDTH_N;
    localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [N-1:0]     DT_W     = N'(DT_FIXED);
    localparam logic signed [N:0] PI_W     = (N+1)'(PI_FIXED);
    localparam logic signed [N:0] TWO_PI_W = (N+1)'(2 * PI_FIXED);
    localparam logic [N-1:0]     SAT_MAX  = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]     SAT_MIN  = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_X,
        ST_MUL_Y,
        ST_MUL_W,
        ST_COMMIT
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]    snap_vx_q, snap_vx_d, snap_vy_q, snap_vy_d, snap_wz_q, snap_wz_d;
    logic [N-1:0]    dx_q, dx_d, dy_q, dy_d, dw_q, dw_d;
    logic [N-1:0]    posx_q, posx_d, posy_q, posy_d, theta_q, theta_d;
    logic [N-1:0]    mula_q, mula_d, mulb_q, mulb_d;
    logic            mulreq_q, mulreq_d;
    logic            update_q, update_d;
    logic            overrun_q, overrun_d;
    logic            tick;

    // Products arrive already rescaled, so FRACTIONAL_Q only documents the format.
    logic unused_frac;
    assign unused_frac = (FRACTIONAL_Q >= 0);

    function automatic logic [N-1:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] sum;
        sum = {a[N-1], a} + {b[N-1], b};
        if (sum[N] != sum[N-1]) begin
            return sum[N] ? SAT_MIN : SAT_MAX;
        end
        return sum[N-1:0];
    endfunction

    // One correction step is enough because |dw| < pi keeps the sum inside (-2pi, 2pi).
    function automatic logic [N-1:0] wrap_theta(input logic [N-1:0] th, input logic [N-1:0] dw);
        logic signed [N:0] t;
        t = {th[N-1], th} + {dw[N-1], dw};
        if (t >= PI_W) begin
            t = t - TWO_PI_W;
        end else if (t < -PI_W) begin
            t = t + TWO_PI_W;
        end
        return t[N-1:0];
    endfunction

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every _d gets its default first, so no path through this block infers a latch.
        state_d   = state_q;
        cnt_d     = tick ? '0 : cnt_q + 1'b1;
        snap_vx_d = snap_vx_q;
        snap_vy_d = snap_vy_q;
        snap_wz_d = snap_wz_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        dw_d      = dw_q;
        posx_d    = posx_q;
        posy_d    = posy_q;
        theta_d   = theta_q;
        update_d  = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    snap_vx_d = POS_SCHED_VX_InBus;
                    snap_vy_d = POS_SCHED_VY_InBus;
                    snap_wz_d = POS_SCHED_WZ_InBus;
                    state_d   = ST_MUL_X;
                end
            end
            ST_MUL_X: begin
                if (POS_SCHED_MULACK_In) begin
                    dx_d    = POS_SCHED_MULP_InBus;
                    state_d = ST_MUL_Y;
                end
            end
            ST_MUL_Y: begin
                if (POS_SCHED_MULACK_In) begin
                    dy_d    = POS_SCHED_MULP_InBus;
                    state_d = ST_MUL_W;
                end
            end
            ST_MUL_W: begin
                if (POS_SCHED_MULACK_In) begin
                    dw_d    = POS_SCHED_MULP_InBus;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                posx_d   = sat_add(posx_q, dx_q);
                posy_d   = sat_add(posy_q, dy_q);
                theta_d  = wrap_theta(theta_q, dw_q);
                update_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A tick that lands on an active sequence is dropped but remembered.
        if (tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        if (!POS_SCHED_SETBEGIN_InLow) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            snap_vx_d = '0;
            snap_vy_d = '0;
            snap_wz_d = '0;
            dx_d      = '0;
            dy_d      = '0;
            dw_d      = '0;
            posx_d    = '0;
            posy_d    = '0;
            theta_d   = '0;
            update_d  = 1'b0;
            overrun_d = 1'b0;
        end

        // Handshake outputs are registered from the next state so they are glitch-free.
        mulreq_d = (state_d == ST_MUL_X) || (state_d == ST_MUL_Y) || (state_d == ST_MUL_W);
        case (state_d)
            ST_MUL_X: mula_d = snap_vx_d;
            ST_MUL_Y: mula_d = snap_vy_d;
            ST_MUL_W: mula_d = snap_wz_d;
            default:  mula_d = '0;
        endcase
        mulb_d = mulreq_d ? DT_W : '0;
    end

    always_ff @(posedge POS_SCHED_CLOCK_50 or negedge POS_SCHED_Reset_InLow) begin
        if (!POS_SCHED_Reset_InLow) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            snap_vx_q <= '0;
            snap_vy_q <= '0;
            snap_wz_q <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            dw_q      <= '0;
            posx_q    <= '0;
            posy_q    <= '0;
            theta_q   <= '0;
            mula_q    <= '0;
            mulb_q    <= '0;
            mulreq_q  <= 1'b0;
            update_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every flop samples pre-edge values regardless of order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            snap_vx_q <= snap_vx_d;
            snap_vy_q <= snap_vy_d;
            snap_wz_q <= snap_wz_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            dw_q      <= dw_d;
            posx_q    <= posx_d;
            posy_q    <= posy_d;
            theta_q   <= theta_d;
            mula_q    <= mula_d;
            mulb_q    <= mulb_d;
            mulreq_q  <= mulreq_d;
            update_q  <= update_d;
            overrun_q <= overrun_d;
        end
    end

    assign POS_SCHED_MULREQ_Out   = mulreq_q;
    assign POS_SCHED_MULA_OutBus  = mula_q;
    assign POS_SCHED_MULB_OutBus  = mulb_q;
    assign POS_SCHED_POSX_OutBus  = posx_q;
    assign POS_SCHED_POSY_OutBus  = posy_q;
    assign POS_SCHED_THETA_OutBus = theta_q;
    assign POS_SCHED_UPDATE_Out   = update_q;
    assign POS_SCHED_OVERRUN_Out  = overrun_q;
    assign POS_SCHED_BUSY_Out     = (state_q != ST_IDLE);

endmodule
